// File: rtl/tile_pkg.sv
// Shared types and constants for the tiling-buffer write sequencer.
package tile_pkg;
  typedef enum logic [2:0] {IDLE, FILL_TOP, FILL_BOT, HOLD, DRAIN} state_e;

  localparam logic [3:0] TOP_MASK = 4'b0101;
  localparam logic [3:0] BOT_MASK = 4'b1010;
  localparam logic [3:0] ALL_MASK = 4'hF;

  function automatic logic [3:0] half_mask(input logic bot);
    return bot ? BOT_MASK : TOP_MASK;
  endfunction
endpackage

// File: rtl/tile_write_ctrl_if.sv
// Row stream, quadrant buffer and tile handshake bundle for tile_write_ctrl.
interface tile_write_ctrl_if #(
  parameter int SIZE_OF_INPUT = 128
);
  logic                     in_valid_i;
  logic [SIZE_OF_INPUT-1:0] in_data_i;
  logic                     in_ready_o;
  logic [3:0]               buf_wr_en_o;
  logic [SIZE_OF_INPUT-1:0] buf_wr_data_o;
  logic [3:0]               buf_rd_en_o;
  logic [3:0]               buf_is_full_i;
  logic [3:0]               buf_is_empty_i;
  logic                     tile_valid_o;
  logic                     tile_ready_i;

  modport master (
    input  in_valid_i, in_data_i, buf_is_full_i, buf_is_empty_i, tile_ready_i,
    output in_ready_o, buf_wr_en_o, buf_wr_data_o, buf_rd_en_o, tile_valid_o
  );

  modport slave (
    output in_valid_i, in_data_i, buf_is_full_i, buf_is_empty_i, tile_ready_i,
    input  in_ready_o, buf_wr_en_o, buf_wr_data_o, buf_rd_en_o, tile_valid_o
  );
endinterface

// File: rtl/tile_write_ctrl_row_counter.sv
// Modulo-ROWS row counter; last_o flags the final row of a half-tile.
module tile_row_counter #(
  parameter int ROWS = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic last_o
);
  localparam int W = $clog2(ROWS) + 1;

  logic [W-1:0] cnt_q, cnt_d;

  // With ROWS==1 the compare is against 0, so every increment is the last.
  assign last_o = (cnt_q == W'(ROWS - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = last_o ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/tile_write_ctrl.sv
// Steers incoming rows into the four quadrant SIPOs and hands full tiles downstream.
// Optional status counters/error flag built only with TILE_WR_CTRL_STATUS_EN.
module tile_write_ctrl
  import tile_pkg::*;
#(
  parameter int SIZE_OF_INPUT  = 128,
  parameter int SIZE_OF_BUFFER = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  tile_write_ctrl_if.master bus,
  output logic [15:0]       tile_cnt_o,
  output logic              ovf_err_o
);
  localparam int ROWS_PER_HALF = SIZE_OF_BUFFER / 2;

  state_e                   state_q, state_d;
  logic [3:0]               wr_en_q, wr_en_d;
  logic [SIZE_OF_INPUT-1:0] wr_data_q, wr_data_d;
  logic [3:0]               rd_en_q, rd_en_d;
  logic                     in_ready, accept, row_last, tile_valid, tile_hs, cnt_clr;
  logic [3:0]               full, empty;

  assign full  = bus.buf_is_full_i;
  assign empty = bus.buf_is_empty_i;

  // Ready never looks at in_valid_i, only at state and the target quadrants.
  assign in_ready   = ((state_q == FILL_TOP) && !full[0] && !full[2]) ||
                      ((state_q == FILL_BOT) && !full[1] && !full[3]);
  assign accept     = bus.in_valid_i && in_ready;
  assign tile_valid = (state_q == HOLD) && (full == ALL_MASK);
  assign tile_hs    = tile_valid && bus.tile_ready_i;
  assign cnt_clr    = (state_q == IDLE) || (state_q == DRAIN);

  tile_row_counter #(.ROWS(ROWS_PER_HALF)) u_row_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (accept),
    .clr_i  (cnt_clr),
    .last_o (row_last)
  );

  always_comb begin
    state_d   = state_q;
    wr_en_d   = accept ? half_mask(state_q == FILL_BOT) : 4'h0;
    wr_data_d = accept ? bus.in_data_i : wr_data_q;
    rd_en_d   = tile_hs ? ALL_MASK : 4'h0;
    unique case (state_q)
      IDLE:     if (empty == ALL_MASK)    state_d = FILL_TOP;
      FILL_TOP: if (accept && row_last)   state_d = FILL_BOT;
      FILL_BOT: if (accept && row_last)   state_d = HOLD;
      HOLD:     if (tile_hs)              state_d = DRAIN;
      DRAIN:    if (empty == ALL_MASK)    state_d = FILL_TOP;
      default:                            state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      wr_en_q   <= 4'h0;
      wr_data_q <= '0;
      rd_en_q   <= 4'h0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      rd_en_q   <= rd_en_d;
    end
  end

  assign bus.in_ready_o    = in_ready;
  assign bus.buf_wr_en_o   = wr_en_q;
  assign bus.buf_wr_data_o = wr_data_q;
  assign bus.buf_rd_en_o   = rd_en_q;
  assign bus.tile_valid_o  = tile_valid;

`ifdef TILE_WR_CTRL_STATUS_EN
  logic [15:0] tile_cnt_q, tile_cnt_d;
  logic        ovf_q, ovf_d;

  // Overflow compares the write actually issued this cycle against live full flags.
  assign tile_cnt_d = tile_hs ? tile_cnt_q + 16'd1 : tile_cnt_q;
  assign ovf_d      = ovf_q || (|(wr_en_q & full));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tile_cnt_q <= 16'd0;
      ovf_q      <= 1'b0;
    end else begin
      tile_cnt_q <= tile_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign tile_cnt_o = tile_cnt_q;
  assign ovf_err_o  = ovf_q;
`else
  assign tile_cnt_o = 16'd0;
  assign ovf_err_o  = 1'b0;
`endif
endmodule

// File: tb/tb_tile_write_ctrl.sv
// Randomised bench for tile_write_ctrl with quadrant buffer models and a row-level reference.
module tb_tile_write_ctrl;
  import tile_pkg::*;

  localparam int W   = 128;
  localparam int B   = 8;
  localparam int RPH = B / 2;
  localparam int MW  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tile_write_ctrl_if #(.SIZE_OF_INPUT(W))  bus ();
  tile_write_ctrl_if #(.SIZE_OF_INPUT(MW)) mbus ();
  logic [15:0] tile_cnt, mcnt;
  logic        ovf, movf;

  tile_write_ctrl #(.SIZE_OF_INPUT(W), .SIZE_OF_BUFFER(B)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .tile_cnt_o(tile_cnt), .ovf_err_o(ovf));
  tile_write_ctrl #(.SIZE_OF_INPUT(MW), .SIZE_OF_BUFFER(2)) dut_min (
    .clk_i(clk), .rst_i(rst), .bus(mbus), .tile_cnt_o(mcnt), .ovf_err_o(movf));

  // quadrant buffer models: count rows per quadrant, flush on rd pulse
  int unsigned qcnt [4];
  int unsigned mq   [4];
  logic [3:0]  force_full, full, empty, mfull, mempty;

  always_comb begin
    full = 4'h0; empty = 4'h0; mfull = 4'h0; mempty = 4'h0;
    for (int q = 0; q < 4; q++) begin
      full[q]   = (qcnt[q] == RPH) || force_full[q];
      empty[q]  = (qcnt[q] == 0);
      mfull[q]  = (mq[q] == 1);
      mempty[q] = (mq[q] == 0);
    end
  end
  assign bus.buf_is_full_i   = full;
  assign bus.buf_is_empty_i  = empty;
  assign mbus.buf_is_full_i  = mfull;
  assign mbus.buf_is_empty_i = mempty;

  always @(posedge clk) begin
    for (int q = 0; q < 4; q++) begin
      if (rst) qcnt[q] <= 0;
      else if (bus.buf_rd_en_o[q]) qcnt[q] <= 0;
      else if (bus.buf_wr_en_o[q] && qcnt[q] < RPH) qcnt[q] <= qcnt[q] + 1;
      if (rst) mq[q] <= 0;
      else if (mbus.buf_rd_en_o[q]) mq[q] <= 0;
      else if (mbus.buf_wr_en_o[q] && mq[q] < 1) mq[q] <= mq[q] + 1;
    end
  end

  int total = 0, bad = 0;
  // reference: rows taken in current tile, waiting-for-empty flag, expected write in flight
  int         idx, tiles;
  bit         blocked, ovf_m;
  logic [3:0] cur_wr, inj;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tmo(input string tag);
    total++; bad++;
    $error("FAIL %s: bound expired", tag);
  endtask

  function automatic logic [15:0] exp_cnt(input int n);
`ifdef TILE_WR_CTRL_STATUS_EN
    return 16'(n);
`else
    return 16'd0;
`endif
  endfunction

  function automatic logic exp_ovf(input bit o);
`ifdef TILE_WR_CTRL_STATUS_EN
    return o;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // one clock of the main DUT, entered and left at a falling edge
  task automatic cyc();
    logic exp_rdy, exp_tv, acc, hs, ovf_nx;
    logic [3:0] mask;
    logic [W-1:0] dat;
    #1;
    exp_rdy = !blocked && idx < B &&
              ((idx < RPH) ? !(full[0] || full[2]) : !(full[1] || full[3]));
    exp_tv  = !blocked && idx == B && full == 4'hF;
    chk("in_ready", W'(bus.in_ready_o), W'(exp_rdy));
    chk("tile_valid", W'(bus.tile_valid_o), W'(exp_tv));
    if (blocked && empty == 4'hF) blocked = 0;
    acc    = bus.in_valid_i && exp_rdy;
    mask   = (idx < RPH) ? TOP_MASK : BOT_MASK;
    dat    = bus.in_data_i;
    hs     = exp_tv && bus.tile_ready_i;
    ovf_nx = |(cur_wr & full);
    @(posedge clk);
    if (inj != 4'h0) begin #1 force_full = inj; inj = 4'h0; end
    @(negedge clk);
    cur_wr = acc ? mask : 4'h0;
    chk("wr_en", W'(bus.buf_wr_en_o), W'(cur_wr));
    if (acc) chk("wr_data", bus.buf_wr_data_o, dat);
    chk("rd_en", W'(bus.buf_rd_en_o), W'(hs ? 4'hF : 4'h0));
    if (acc) idx++;
    if (hs) begin idx = 0; blocked = 1; tiles++; end
    if (ovf_nx) ovf_m = 1;
    chk("tile_cnt", W'(tile_cnt), W'(exp_cnt(tiles)));
    chk("ovf_err", W'(ovf), W'(exp_ovf(ovf_m)));
  endtask

  task automatic do_reset();
    rst = 1'b1; force_full = 4'h0; inj = 4'h0;
    @(posedge clk); @(negedge clk); #1;
    chk("rst_in_ready", W'(bus.in_ready_o), '0);
    chk("rst_wr_en", W'(bus.buf_wr_en_o), '0);
    chk("rst_wr_data", bus.buf_wr_data_o, '0);
    chk("rst_rd_en", W'(bus.buf_rd_en_o), '0);
    chk("rst_tile_valid", W'(bus.tile_valid_o), '0);
    chk("rst_tile_cnt", W'(tile_cnt), '0);
    chk("rst_ovf", W'(ovf), '0);
    rst = 1'b0;
    idx = 0; tiles = 0; blocked = 1; ovf_m = 0; cur_wr = 4'h0;
  endtask

  initial begin
    int n;
    logic [W-1:0] held;
    logic [MW-1:0] mdat;
    bus.in_valid_i = 0; bus.in_data_i = '0; bus.tile_ready_i = 0;
    mbus.in_valid_i = 0; mbus.in_data_i = '0; mbus.tile_ready_i = 0;
    force_full = 4'h0; inj = 4'h0;
    @(negedge clk);
    do_reset();

    // nominal back-to-back fill; tile presented 2 cycles after the 8th accept
    bus.in_valid_i = 1;
    for (int i = 0; i < 12; i++) begin bus.in_data_i = rnd(); cyc(); end
    chk("nominal_tile_valid", W'(bus.tile_valid_o), W'(1));

    // downstream stalls 5 cycles then takes the tile
    for (int i = 0; i < 5; i++) cyc();
    bus.tile_ready_i = 1; cyc();
    bus.tile_ready_i = 0;
    chk("hs_rd_pulse", W'(bus.buf_rd_en_o), W'(4'hF));

    // backpressure on quadrant 2 while row 2 is offered
    n = 0;
    while (idx < 2 && n < 20) begin bus.in_data_i = rnd(); cyc(); n++; end
    if (idx < 2) tmo("bp_reach_row2");
    bus.in_valid_i = 0; cyc();
    held = rnd(); bus.in_data_i = held; bus.in_valid_i = 1; force_full = 4'b0100;
    for (int i = 0; i < 3; i++) cyc();
    force_full = 4'h0;
    cyc();
    chk("bp_held_row", bus.buf_wr_data_o, held);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      bus.in_valid_i   = ($urandom_range(3) != 0);
      bus.in_data_i    = rnd();
      bus.tile_ready_i = ($urandom_range(2) == 0);
      force_full = (cur_wr == 4'h0 && $urandom_range(7) == 0) ? 4'(1 << $urandom_range(3)) : 4'h0;
      cyc();
    end
    force_full = 4'h0;

    // reset after row 5 of a tile, refill restarts at the top half
    bus.in_valid_i = 1; bus.tile_ready_i = 1; n = 0;
    while (idx != 5 && n < 100) begin bus.in_data_i = rnd(); cyc(); n++; end
    if (idx != 5) tmo("reach_row5");
    do_reset();
    n = 0;
    while (idx != 1 && n < 10) begin bus.in_data_i = rnd(); cyc(); n++; end
    if (idx != 1) tmo("restart_accept");
    chk("restart_mask", W'(bus.buf_wr_en_o), W'(TOP_MASK));

    // three complete tiles, then a write forced against full flags
    n = 0;
    while (tiles < 3 && n < 200) begin bus.in_data_i = rnd(); cyc(); n++; end
    if (tiles < 3) tmo("three_tiles");
    chk("three_tiles_cnt", W'(tile_cnt), W'(exp_cnt(3)));
    bus.tile_ready_i = 0; n = 0;
    while (n < 20) begin
      n++;
      if (!blocked && idx < RPH) begin inj = 4'b0101; cyc(); break; end
      cyc();
    end
    for (int i = 0; i < 3; i++) cyc();
    force_full = 4'h0;
    for (int i = 0; i < 4; i++) cyc();
    chk("ovf_sticky", W'(ovf), W'(exp_ovf(1'b1)));
    bus.in_valid_i = 0;
    do_reset();

    // SIZE_OF_BUFFER=2 instance: masks alternate, tile every 2 rows
    mbus.in_valid_i = 1;
    for (int t = 0; t < 3; t++) begin
      for (int r = 0; r < 2; r++) begin
        n = 0; #1;
        while (!mbus.in_ready_o && n < 10) begin @(negedge clk); #1; n++; end
        if (n == 10) tmo("min_ready");
        mdat = MW'($urandom); mbus.in_data_i = mdat;
        @(posedge clk); @(negedge clk);
        chk("min_wr_en", W'(mbus.buf_wr_en_o), W'(r == 0 ? TOP_MASK : BOT_MASK));
        chk("min_wr_data", W'(mbus.buf_wr_data_o), W'(mdat));
      end
      mbus.in_valid_i = 0; n = 0; #1;
      while (!mbus.tile_valid_o && n < 10) begin @(negedge clk); #1; n++; end
      chk("min_tile_valid", W'(mbus.tile_valid_o), W'(1));
      mbus.tile_ready_i = 1;
      @(posedge clk); @(negedge clk);
      mbus.tile_ready_i = 0; mbus.in_valid_i = 1;
      chk("min_rd_en", W'(mbus.buf_rd_en_o), W'(4'hF));
    end
    mbus.in_valid_i = 0;
    chk("min_tile_cnt", W'(mcnt), W'(exp_cnt(3)));
    chk("min_ovf", W'(movf), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/tile_write_ctrl.md
# tile_write_ctrl

Upstream sequencer for the four-quadrant tiling buffer. Accepts a stream of SIZE_OF_INPUT-bit rows over a valid/ready handshake and steers them into the quadrant SIPOs: the first SIZE_OF_BUFFER/2 rows of a tile go to the top quadrants, the next SIZE_OF_BUFFER/2 to the bottom quadrants. Once all four quadrants are full it presents a tile to the downstream consumer, then issues the read pulse and waits for drain before refilling.

## Interface
- SIZE_OF_INPUT, 128: row width in bits; must be even. Low half feeds the left quadrants, high half the right quadrants.
- SIZE_OF_BUFFER, 8: rows per tile; must be even and ≥2. ROWS_PER_HALF = SIZE_OF_BUFFER/2.
- clk_i  in  1  single clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  upstream row valid.
- in_data_i  in  SIZE_OF_INPUT  upstream row.
- in_ready_o  out  1  row accepted when in_valid_i & in_ready_o.
- buf_wr_en_o  out  4  per-quadrant write enable (bit0 top-left, bit1 bottom-left, bit2 top-right, bit3 bottom-right).
- buf_wr_data_o  out  SIZE_OF_INPUT  registered row to the buffer.
- buf_rd_en_o  out  4  per-quadrant read/flush pulse.
- buf_is_full_i  in  4  quadrant full flags.
- buf_is_empty_i  in  4  quadrant empty flags.
- tile_valid_o  out  1  complete tile is present in the buffer.
- tile_ready_i  in  1  downstream has captured the tile.
- tile_cnt_o  out  16  completed-tile count (status feature).
- ovf_err_o  out  1  sticky write-to-full error (status feature).

## Operation
- FSM states: IDLE, FILL_TOP, FILL_BOT, HOLD, DRAIN. Reset enters IDLE.
- IDLE: the block moves to FILL_TOP on the next cycle when buf_is_empty_i==4'hF. Otherwise it stays in IDLE.
- FILL_TOP: in_ready_o = ~buf_is_full_i[0] & ~buf_is_full_i[2].
  - On accept: buf_wr_en_o=4'b0101 next cycle, row_cnt increments.
  - When row ROWS_PER_HALF-1 is accepted, row_cnt clears and the FSM goes to FILL_BOT.
- FILL_BOT: same as FILL_TOP, but uses mask 4'b1010 and gates in_ready_o with bits [1] and [3]. The final accept moves the FSM to HOLD.
- HOLD: in_ready_o=0. tile_valid_o = (buf_is_full_i==4'hF), which waits out the one-cycle write lag.
  - On tile_valid_o & tile_ready_i: buf_rd_en_o=4'hF for exactly one cycle, tile_cnt increments, and the FSM goes to DRAIN.
- DRAIN: in_ready_o=0. When buf_is_empty_i==4'hF, the FSM goes to FILL_TOP.
- in_ready_o is combinational from state and full flags; it never depends on in_valid_i.
- row_cnt width is $clog2(ROWS_PER_HALF)+1. When ROWS_PER_HALF==1, every accept is the last row of its half.
- tile_ready_i while tile_valid_o=0 is ignored.
- in_valid_i outside the FILL states is held off (ready=0); no data is lost.

## Timing
- Reset values: in_ready_o=0, buf_wr_en_o=0, buf_wr_data_o=0, buf_rd_en_o=0, tile_valid_o=0, tile_cnt_o=0, ovf_err_o=0, row_cnt=0.
- Write latency: an accept in cycle N gives buf_wr_en_o/buf_wr_data_o valid in cycle N+1, held for exactly one cycle.
- Throughput: one row per cycle while not full. A full tile takes SIZE_OF_BUFFER accept cycles, plus HOLD, the rd pulse and DRAIN.
- Earliest tile_valid_o is 2 cycles after the last accept: one cycle for the write, one for the full-flag registration.
- buf_rd_en_o is asserted in the cycle after the tile handshake.
- rst_i mid-tile: all outputs return to reset values in the next cycle. Any pending write is discarded. The FSM re-enters IDLE and waits for all-empty before filling.

## Configuration
- TILE_WR_CTRL_STATUS_EN defined:
  - tile_cnt_o counts tile handshakes and wraps at 2^16.
  - ovf_err_o sets when any bit of buf_wr_en_o is asserted while the matching buf_is_full_i bit is 1, and clears only on rst_i.
- Undefined: tile_cnt_o and ovf_err_o are tied to 0, and the counter and error logic are not built. Ports remain present.

## Structure
- Shared package tile_pkg:
  - state enum: IDLE, FILL_TOP, FILL_BOT, HOLD, DRAIN
  - localparams TOP_MASK=4'b0101, BOT_MASK=4'b1010, ALL_MASK=4'hF
- One sub-module, tile_row_counter: parameterised modulo-ROWS_PER_HALF counter with inc, clr and a last flag.

## Test plan
- Nominal fill: 8 back-to-back rows with in_valid_i held at 1, ready held high, defaults.
  - buf_wr_en_o reads 0101 ×4 then 1010 ×4, one cycle behind each accept.
  - buf_wr_data_o matches the rows in order.
  - Once the buffer model reports 4'hF full, tile_valid_o=1.
- Backpressure: buffer model holds buf_is_full_i[2]=1 during row 2.
  - in_ready_o=0, no write issues, and the row is held until the flag drops.
- Tile handshake: tile_ready_i is low for 5 cycles, then high for 1.
  - tile_valid_o stays high throughout.
  - A single buf_rd_en_o=4'hF pulse follows.
  - in_ready_o returns only after buf_is_empty_i==4'hF.
- Reset mid-fill: rst_i asserted after row 5.
  - All outputs are 0 next cycle.
  - The next fill restarts at TOP_MASK with row_cnt=0.
- Status (TILE_WR_CTRL_STATUS_EN): 3 complete tiles, then a forced write while the full flag is set.
  - tile_cnt_o=3 and ovf_err_o=1 sticky until reset.
  - With the macro undefined, both read 0.
- Minimal config, SIZE_OF_BUFFER=2:
  - masks alternate 0101, 1010 per row.
  - A tile is presented after every 2 rows.
